// File: rtl/uart_cfg_ctrl.sv
// Configuration controller: handshakes decoded register writes, holds a 16x4
// register file, and sequences baud changes (drop baud_ready, settle, re-arm).
module uart_cfg_ctrl #(
  parameter int         SETTLE_CYCLES = 32,
  parameter logic [3:0] BAUD_ADDR     = 4'h0,
  parameter logic [3:0] CLR_ADDR      = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [3:0] address,
  input  logic [3:0] data,
  output logic       ack,
  input  logic [3:0] rd_addr,
  output logic [3:0] rd_data,
  output logic [2:0] baud,
  output logic       baud_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    BAUD_SET,
    SETTLE,
    ACK,
    RELEASE
  } state_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] MAX_BAUD    = 4'd4;

  state_t     state, next_state;
  logic [3:0] lat_addr;
  logic [3:0] lat_data;
  logic [7:0] count;
  logic [3:0] regs [16];
  logic       baud_legal;

  assign baud_legal = (lat_data <= MAX_BAUD);
  assign busy       = (state != IDLE);

  // NOTE: next-state logic assigns a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (valid) next_state = (address == BAUD_ADDR) ? BAUD_SET : WRITE;
      WRITE:    next_state = ACK;
      BAUD_SET: next_state = baud_legal ? SETTLE : ACK;
      SETTLE:   if (count == 8'd0) next_state = ACK;
      ACK:      next_state = RELEASE;
      RELEASE:  if (!valid) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which also gives rd_data its read-old-value behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // ack is the registered image of the ACK state, landing one cycle after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr   <= 4'h0;
      lat_data   <= 4'h0;
      count      <= 8'd0;
      baud       <= 3'b001;
      baud_ready <= 1'b1;
      err        <= 1'b0;
      ack        <= 1'b0;
      rd_data    <= 4'h0;
      // NOTE: the register file is small and has architected reset values
      // (baud register mirrors baud), so it is reset explicitly.
      for (int i = 0; i < 16; i++) regs[i] <= 4'h0;
      regs[BAUD_ADDR] <= 4'h1;
    end else begin
      ack     <= (state == ACK);
      rd_data <= regs[rd_addr];
      case (state)
        IDLE: begin
          if (valid) begin
            lat_addr <= address;
            lat_data <= data;
          end
        end
        WRITE: begin
          regs[lat_addr] <= lat_data;
          if (lat_addr == CLR_ADDR) err <= 1'b0;
        end
        BAUD_SET: begin
          if (baud_legal) begin
            baud            <= lat_data[2:0];
            regs[BAUD_ADDR] <= lat_data;
            baud_ready      <= 1'b0;
            count           <= SETTLE_INIT;
          end else begin
            err <= 1'b1;
          end
        end
        SETTLE: begin
          if (count == 8'd0) baud_ready <= 1'b1;
          else               count      <= count - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Self-checking bench for uart_cfg_ctrl: directed scenarios plus random writes
// compared against a transaction-level model of the register file and baud state.
module tb_uart_cfg_ctrl;

  localparam int         S    = 32;
  localparam logic [3:0] BADR = 4'h0;
  localparam logic [3:0] CADR = 4'hF;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [3:0] address;
  logic [3:0] data;
  logic       ack;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic [2:0] baud;
  logic       baud_ready;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_regs [16];
  logic [2:0] m_baud;
  logic       m_err;

  uart_cfg_ctrl #(.SETTLE_CYCLES(S), .BAUD_ADDR(BADR), .CLR_ADDR(CADR)) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .data(data),
    .ack(ack), .rd_addr(rd_addr), .rd_data(rd_data), .baud(baud),
    .baud_ready(baud_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 4'h0;
    m_regs[BADR] = 4'h1;
    m_baud       = 3'b001;
    m_err        = 1'b0;
  endtask

  // One write transaction. hold: cycles valid stays high after ack is seen.
  // early: valid dropped right after acceptance (protocol violation).
  task automatic do_write(input string name, input logic [3:0] a, input logic [3:0] d,
                          input int hold, input bit early);
    int exp_ack, ack_k, acks, br_low, drop_k, busy_fall;
    bit legal, is_baud, busy_ok, done;
    is_baud   = (a == BADR);
    legal     = is_baud && (d <= 4'd4);
    exp_ack   = legal ? S + 2 : 2;
    ack_k     = -1;
    acks      = 0;
    br_low    = 0;
    drop_k    = -1;
    busy_fall = -1;
    busy_ok   = 1'b1;
    done      = 1'b0;

    if (is_baud) begin
      if (legal) begin
        m_baud  = d[2:0];
        m_regs[BADR] = d;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_regs[a] = d;
      if (a == CADR) m_err = 1'b0;
    end

    valid = 1'b1; address = a; data = d;
    tick();
    if (early) begin
      valid  = 1'b0;
      drop_k = 0;
    end
    for (int k = 1; k <= S + 80 && !done; k++) begin
      tick();
      if (ack === 1'b1) begin
        acks++;
        if (ack_k < 0) ack_k = k;
      end
      if (baud_ready !== 1'b1) br_low++;
      if (k == 1) begin
        check({name, "_baud"},  baud, m_baud);
        check({name, "_ready"}, baud_ready, legal ? 1'b0 : 1'b1);
        check({name, "_err"},   err, m_err);
      end
      if (drop_k >= 0) busy_fall = (drop_k + 1 > exp_ack + 1) ? drop_k + 1 : exp_ack + 1;
      if (busy_fall >= 0 && k == busy_fall) begin
        check({name, "_busy_fall"}, busy, 1'b0);
        done = 1'b1;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      if (drop_k < 0 && ack_k >= 0 && k >= ack_k + hold) begin
        valid  = 1'b0;
        drop_k = k;
      end
    end
    valid = 1'b0;
    check({name, "_done"},     done, 1'b1);
    check({name, "_ack_time"}, ack_k, exp_ack);
    check({name, "_ack_cnt"},  acks, 1);
    check({name, "_busy"},     busy_ok, 1'b1);
    if (is_baud) check({name, "_ready_low"}, br_low, legal ? S : 0);

    rd_addr = a;
    tick();
    check({name, "_rd"}, rd_data, m_regs[a]);
    rd_addr = BADR;
    tick();
    check({name, "_rd_baud"}, rd_data, {1'b0, m_baud});
    check({name, "_err_after"}, err, m_err);
    check({name, "_ready_after"}, baud_ready, 1'b1);
  endtask

  initial begin
    int ack_seen;
    logic [3:0] ra, rdd;
    int rh;
    bit re;

    // Reset
    rst = 1'b0; valid = 1'b0; address = 4'h0; data = 4'h0; rd_addr = 4'h0;
    model_reset();
    tick(); tick();
    check("rst_baud",  baud, 3'b001);
    check("rst_ready", baud_ready, 1'b1);
    check("rst_ack",   ack, 1'b0);
    check("rst_err",   err, 1'b0);
    check("rst_busy",  busy, 1'b0);
    check("rst_rd",    rd_data, 4'h0);
    rst = 1'b1;
    tick();
    check("rst_rd_baudreg", rd_data, 4'h1);

    // Directed scenarios
    do_write("normal",   4'h3, 4'hA, 0, 1'b0);
    do_write("baud3",    BADR, 4'h3, 0, 1'b0);
    do_write("illegal",  BADR, 4'h7, 0, 1'b0);
    do_write("clr",      CADR, 4'h5, 0, 1'b0);
    do_write("held",     4'h6, 4'h9, 20, 1'b0);
    do_write("rebaud",   BADR, 4'h3, 0, 1'b0);
    do_write("baud4",    BADR, 4'h4, 1, 1'b0);
    do_write("illegal5", BADR, 4'h5, 0, 1'b1);
    do_write("early",    4'h2, 4'hC, 0, 1'b1);
    do_write("clr2",     CADR, 4'h0, 2, 1'b0);

    // Random writes
    for (int i = 0; i < 16; i++) begin
      ra  = ($urandom_range(0, 2) == 0) ? BADR : 4'($urandom_range(0, 15));
      rdd = 4'($urandom_range(0, 15));
      rh  = $urandom_range(0, 3);
      re  = ($urandom_range(0, 5) == 0);
      do_write("rand", ra, rdd, rh, re);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      tick();
      check("sweep_rd", rd_data, m_regs[i]);
    end

    // Reset in the middle of a settle interval
    ack_seen = 0;
    valid = 1'b1; address = BADR; data = 4'h2;
    tick();
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (ack === 1'b1) ack_seen++;
    end
    check("mid_baud_pre",  baud, 3'b010);
    check("mid_ready_pre", baud_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_baud",  baud, 3'b001);
    check("mid_ready", baud_ready, 1'b1);
    check("mid_busy",  busy, 1'b0);
    valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    model_reset();
    rd_addr = BADR;
    for (int k = 0; k < S + 4; k++) begin
      tick();
      if (ack === 1'b1) ack_seen++;
    end
    check("mid_no_ack", ack_seen, 0);
    check("mid_rd",     rd_data, m_regs[BADR]);
    check("mid_ready_after", baud_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
